// File: rtl/gold_gen_pkg.sv
// Shared types, constants and the LFSR step rule for the Gold/M-sequence generator.
package gold_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic GOLD  = 1'b0;  // chip = out1 ^ out2
    localparam logic MONLY = 1'b1;  // chip = out1

    // Widest LFSR the step helper supports; narrower callers zero-extend.
    localparam int MAX_LEN = 32;

    // One Fibonacci step: shift right, feedback (parity of tapped bits) enters at bit len-1.
    function automatic logic [MAX_LEN-1:0] lfsr_next(
        input logic [MAX_LEN-1:0] state,
        input logic [MAX_LEN-1:0] poly,
        input int                 len
    );
        logic fb;
        fb = ^(state & poly);
        return (state >> 1) | ({{(MAX_LEN-1){1'b0}}, fb} << (len - 1));
    endfunction

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR with synchronous load (priority) and step enable.
module lfsr_fib
    import gold_gen_pkg::*;
#(
    parameter int                LENGTH = 6,
    parameter logic [LENGTH-1:0] POLY   = 6'b000011
) (
    input  logic              clkin,
    input  logic              rstn,
    input  logic              load,
    input  logic [LENGTH-1:0] seed,
    input  logic              step,
    output logic              out,
    output logic [LENGTH-1:0] state
);

    logic [LENGTH-1:0] state_q, state_d;

    // Next state: a load overrides a step; otherwise hold.
    always_comb begin
        // NOTE: assign a default first so every path writes state_d and no latch is inferred.
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = LENGTH'(lfsr_next(MAX_LEN'(state_q), MAX_LEN'(POLY), LENGTH));
        end
    end

    // State register.
    always_ff @(posedge clkin or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign out   = state_q[0];
    assign state = state_q;

endmodule

// File: rtl/gold_gen_param.sv
// Parametrised Gold/M-sequence chip generator: seeds in over AXI-stream, chips out
// over AXI-stream with per-chip hold, period framing, repeat count and graceful stop.
module gold_gen_param
    import gold_gen_pkg::*;
#(
    parameter int                LENGTH = 6,
    parameter logic [LENGTH-1:0] POLY1  = 6'b000011,
    parameter logic [LENGTH-1:0] POLY2  = 6'b100111,
    parameter int                HOLD   = 3,
    parameter int                RPT_W  = 16
) (
    input  logic              clkin,
    input  logic              rstn,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [LENGTH-1:0] s_tdata,
    input  logic [LENGTH-1:0] s_tuser,
    input  logic              cfg_mode,
    input  logic [RPT_W-1:0]  cfg_repeat,
    input  logic              stop_i,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tdata,
    output logic              m_tlast,
    output logic              strobe_sig_o,
    output logic              busy_o,
    output logic              err_zero_seed_o
);

    localparam int                N         = 2**LENGTH - 1;
    localparam int                HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD - 1);
    localparam logic [LENGTH-1:0] CHIP_LAST = LENGTH'(N - 1);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [RPT_W-1:0]   repeat_q, repeat_d;
    logic [RPT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [LENGTH-1:0]  chip_cnt_q, chip_cnt_d;
    logic               stop_q, stop_d;
    logic               err_q, err_d;

    logic               run;
    logic               accept;
    logic               hold_wrap;
    logic               beat_last;
    logic               seed_hs;
    logic               seed_bad;
    logic               load;
    logic               step;
    logic               out1, out2;
    logic [LENGTH-1:0]  lfsr1_state, lfsr2_state;

    assign run       = (state_q == RUN);
    assign accept    = run && m_tready;
    assign hold_wrap = (hold_cnt_q == HOLD_LAST);
    assign beat_last = (chip_cnt_q == CHIP_LAST) && hold_wrap;
    assign seed_hs   = (state_q == IDLE) && s_tvalid;
    // LFSR1 always drives the output; LFSR2 only matters in Gold mode.
    assign seed_bad  = (s_tuser == '0) || ((cfg_mode == GOLD) && (s_tdata == '0));
    assign load      = seed_hs && !seed_bad;
    assign step      = accept && hold_wrap;

    lfsr_fib #(.LENGTH(LENGTH), .POLY(POLY1)) u_lfsr1 (
        .clkin (clkin),
        .rstn  (rstn),
        .load  (load),
        .seed  (s_tuser),
        .step  (step),
        .out   (out1),
        .state (lfsr1_state)
    );

    lfsr_fib #(.LENGTH(LENGTH), .POLY(POLY2)) u_lfsr2 (
        .clkin (clkin),
        .rstn  (rstn),
        .load  (load),
        .seed  (s_tdata),
        .step  (step),
        .out   (out2),
        .state (lfsr2_state)
    );

    // Next-state logic: seed acceptance in IDLE, beat/chip/period counting in RUN.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        repeat_d   = repeat_q;
        per_cnt_d  = per_cnt_q;
        hold_cnt_d = hold_cnt_q;
        chip_cnt_d = chip_cnt_q;
        stop_d     = stop_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_hs) begin
                    if (seed_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        mode_d     = cfg_mode;
                        repeat_d   = cfg_repeat;
                        per_cnt_d  = '0;
                        hold_cnt_d = '0;
                        chip_cnt_d = '0;
                        stop_d     = 1'b0;
                    end
                end
            end
            RUN: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                if (accept) begin
                    if (hold_wrap) begin
                        hold_cnt_d = '0;
                        chip_cnt_d = (chip_cnt_q == CHIP_LAST) ? '0 : chip_cnt_q + 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    // A period only ends on its tlast beat, so stop never truncates one;
                    // a stop arriving on that very beat still counts.
                    if (beat_last) begin
                        per_cnt_d = per_cnt_q + 1'b1;
                        if (stop_q || stop_i || ((repeat_q != '0) && (per_cnt_d == repeat_q))) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mode_q     <= GOLD;
            repeat_q   <= '0;
            per_cnt_q  <= '0;
            hold_cnt_q <= '0;
            chip_cnt_q <= '0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            repeat_q   <= repeat_d;
            per_cnt_q  <= per_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            chip_cnt_q <= chip_cnt_d;
            stop_q     <= stop_d;
            err_q      <= err_d;
        end
    end

    // Zero-seed rejection keeps every LFSR that feeds the output out of the all-zero state.
    always_ff @(posedge clkin) begin
        if (rstn && run) begin
            assert (lfsr1_state != '0);
            assert ((mode_q == MONLY) || (lfsr2_state != '0));
        end
    end

    assign s_tready        = (state_q == IDLE);
    assign m_tvalid        = run;
    assign m_tdata         = run && ((mode_q == MONLY) ? out1 : (out1 ^ out2));
    assign m_tlast         = run && beat_last;
    assign strobe_sig_o    = accept && (chip_cnt_q == '0) && (hold_cnt_q == '0);
    assign busy_o          = run;
    assign err_zero_seed_o = err_q;

endmodule
